// File: rtl/imem_loader_pkg.sv
// Shared constants and types for the IMEM Wishbone loader.
package imem_loader_pkg;

  // Offsets within the loader's 8 KiB decode region.
  localparam logic [12:0] OFF_IMEM_LO = 13'h0000;
  localparam logic [12:0] OFF_IMEM_HI = 13'h07FF;
  localparam logic [12:0] OFF_CTRL    = 13'h1000;
  localparam logic [12:0] OFF_STATUS  = 13'h1004;

  // CTRL / STATUS bit positions.
  localparam int CTRL_CORE_RESET_BIT = 0;
  localparam int CTRL_LOAD_EN_BIT    = 1;
  localparam int STATUS_BUSY_BIT     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWR,
    ST_SRD,
    ST_SCAP,
    ST_ACK
  } loader_state_e;

  // The IMEM window is power-of-two sized and aligned, so a masked compare decodes it.
  function automatic logic in_imem_window(input logic [12:0] off);
    return (off & ~(OFF_IMEM_HI ^ OFF_IMEM_LO)) == OFF_IMEM_LO;
  endfunction

endpackage

// File: rtl/imem_loader_regs.sv
// CTRL/STATUS registers and the saturating IMEM write counter.
import imem_loader_pkg::*;

module imem_loader_regs #(
  parameter int CNT_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_we,
  input  logic [1:0]  ctrl_wdata,
  input  logic        cnt_inc,
  output logic        core_reset,
  output logic        load_en,
  output logic [31:0] ctrl_rdata,
  output logic [31:0] status_rdata
);

  logic             core_reset_q, core_reset_d;
  logic             load_en_q, load_en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state for CTRL bits and the write counter.
  always_comb begin
    core_reset_d = core_reset_q;
    load_en_d    = load_en_q;
    cnt_d        = cnt_q;
    if (ctrl_we) begin
      core_reset_d = ctrl_wdata[CTRL_CORE_RESET_BIT];
      load_en_d    = ctrl_wdata[CTRL_LOAD_EN_BIT];
      // Opening a new load session starts the count from zero.
      if (ctrl_wdata[CTRL_LOAD_EN_BIT] && !load_en_q) begin
        cnt_d = '0;
      end
    end
    if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Register state; the core is held in reset until software releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_reset_q <= 1'b1;
      load_en_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      core_reset_q <= core_reset_d;
      load_en_q    <= load_en_d;
      cnt_q        <= cnt_d;
    end
  end

  // Read-back words; busy is never set because accesses are serialised by the FSM.
  always_comb begin
    ctrl_rdata                      = '0;
    ctrl_rdata[CTRL_CORE_RESET_BIT] = core_reset_q;
    ctrl_rdata[CTRL_LOAD_EN_BIT]    = load_en_q;
    status_rdata                    = '0;
    status_rdata[CNT_W-1:0]         = cnt_q;
    status_rdata[STATUS_BUSY_BIT]   = 1'b0;
  end

  assign core_reset = core_reset_q;
  assign load_en    = load_en_q;

endmodule

// File: rtl/imem_wb_loader.sv
// Wishbone responder giving the management SoC load/read-back access to IMEM port 0.
//
// state | meaning
// IDLE  | waiting for a request in the decode region
// SWR   | SRAM write strobe active this cycle
// SRD   | SRAM read strobe active this cycle
// SCAP  | capture SRAM read data
// ACK   | one-cycle acknowledge (suppressed if the master aborted)
import imem_loader_pkg::*;

module imem_wb_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          IMEM_AW   = 9,
  parameter int          CNT_W     = 10
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               sram_csb0,
  output logic               sram_web0,
  output logic [3:0]         sram_wmask0,
  output logic [IMEM_AW-1:0] sram_addr0,
  output logic [31:0]        sram_din0,
  input  logic [31:0]        sram_dout0,
  output logic               core_reset
);

  loader_state_e      state_q, state_d;
  logic               ack_q, ack_d;
  logic               abort_q, abort_d;
  logic [31:0]        dat_q, dat_d;
  logic               csb_q, csb_d;
  logic               web_q, web_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [31:0]        din_q, din_d;

  logic               ctrl_we, cnt_inc, load_en;
  logic [31:0]        ctrl_rdata, status_rdata;

  logic [12:0]        offset_w;
  logic               region_hit, req, imem_hit, ctrl_hit, status_hit;
  logic [IMEM_AW-1:0] word_w;

  assign offset_w   = wbs_adr_i[12:0];
  assign region_hit = (wbs_adr_i[31:13] == BASE_ADDR[31:13]);
  assign req        = wbs_cyc_i & wbs_stb_i & region_hit;
  assign imem_hit   = in_imem_window(offset_w);
  assign ctrl_hit   = (offset_w == OFF_CTRL);
  assign status_hit = (offset_w == OFF_STATUS);
  assign word_w     = wbs_adr_i[IMEM_AW+1:2];

  imem_loader_regs #(
    .CNT_W(CNT_W)
  ) u_regs (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .ctrl_we     (ctrl_we),
    .ctrl_wdata  (wbs_dat_i[1:0]),
    .cnt_inc     (cnt_inc),
    .core_reset  (core_reset),
    .load_en     (load_en),
    .ctrl_rdata  (ctrl_rdata),
    .status_rdata(status_rdata)
  );

  // Next-state, SRAM strobe and bus response decisions.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    abort_d = abort_q;
    dat_d   = dat_q;
    csb_d   = csb_q;
    web_d   = web_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ctrl_we = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (req) begin
          if (imem_hit && load_en) begin
            csb_d  = 1'b0;
            addr_d = word_w;
            if (wbs_we_i) begin
              web_d   = 1'b0;
              din_d   = wbs_dat_i;
              wmask_d = wbs_sel_i;
              state_d = ST_SWR;
            end else begin
              web_d   = 1'b1;
              state_d = ST_SRD;
            end
          end else begin
            ack_d   = 1'b1;
            state_d = ST_ACK;
            if (imem_hit) begin
              dat_d = '0;
            end else if (wbs_we_i) begin
              ctrl_we = ctrl_hit & wbs_sel_i[0];
            end else if (ctrl_hit) begin
              dat_d = ctrl_rdata;
            end else if (status_hit) begin
              dat_d = status_rdata;
            end else begin
              dat_d = '0;
            end
          end
        end
      end
      ST_SWR: begin
        // The write lands on this edge even if the master has gone away.
        csb_d   = 1'b1;
        web_d   = 1'b1;
        cnt_inc = 1'b1;
        abort_d = abort_q | ~wbs_cyc_i;
        ack_d   = wbs_cyc_i & ~abort_q;
        state_d = ST_ACK;
      end
      ST_SRD: begin
        csb_d   = 1'b1;
        abort_d = abort_q | ~wbs_cyc_i;
        state_d = ST_SCAP;
      end
      ST_SCAP: begin
        dat_d   = sram_dout0;
        abort_d = abort_q | ~wbs_cyc_i;
        ack_d   = wbs_cyc_i & ~abort_q;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        csb_d   = 1'b1;
        web_d   = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset always parks the SRAM port deselected.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      abort_q <= 1'b0;
      dat_q   <= '0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      abort_q <= abort_d;
      dat_q   <= dat_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;

endmodule

// File: tb/tb_imem_wb_loader.sv
// Self-checking bench for imem_wb_loader: transaction-level model plus per-cycle monitor.
`timescale 1ns/1ps

module tb_imem_wb_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0, sram_dout0;
  logic        core_reset;

  always #5 wb_clk_i = ~wb_clk_i;

  imem_wb_loader dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_wmask0(sram_wmask0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0),
    .core_reset (core_reset)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state.
  logic [31:0] m_mem [512];
  logic        m_core_reset, m_load_en;
  int          m_cnt;

  // SRAM macro contents (environment, not the reference).
  logic [31:0] sram_mem [512];

  // Expectations for the transaction in flight, consumed by the monitor.
  logic        pending, mon_on, exp_web, exp_rd;
  logic [8:0]  exp_addr;
  logic [31:0] exp_din, exp_dat;
  logic [3:0]  exp_wmask;
  int          exp_csb_cnt, csb_cnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Synchronous SRAM port 0: samples csb/web/addr on the rising edge, read data follows.
  initial begin
    sram_dout0 <= '0;
    forever begin
      @(posedge wb_clk_i);
      if (sram_csb0 === 1'b0) begin
        if (sram_web0 === 1'b0) begin
          for (int b = 0; b < 4; b++)
            if (sram_wmask0[b]) sram_mem[sram_addr0][8*b +: 8] = sram_din0[8*b +: 8];
        end else begin
          sram_dout0 <= sram_mem[sram_addr0];
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge wb_clk_i);
      #2;
      if (mon_on) begin
        check("core_reset", 32'(core_reset), 32'(m_core_reset));
        if (sram_csb0 === 1'b0) begin
          csb_cnt++;
          check("sram_web0", 32'(sram_web0), 32'(exp_web));
          check("sram_addr0", 32'(sram_addr0), 32'(exp_addr));
          if (!exp_web) begin
            check("sram_din0", sram_din0, exp_din);
            check("sram_wmask0", 32'(sram_wmask0), 32'(exp_wmask));
          end
        end
        if (wbs_ack_o === 1'b1) begin
          check("ack_expected", 32'(pending), 32'd1);
          if (pending) begin
            pending = 1'b0;
            check("sram_cycles", 32'(csb_cnt), 32'(exp_csb_cnt));
            if (exp_rd) check("rd_data", wbs_dat_o, exp_dat);
          end
        end
      end
    end
  end

  function automatic logic is_imem(input logic [12:0] off);
    return off < 13'h0800;
  endfunction

  // Apply the architectural effect of a completed (or aborted-but-issued) write.
  task automatic model_write(input logic [12:0] off, input logic [3:0] sel, input logic [31:0] dat);
    logic [8:0] word;
    word = off[10:2];
    if (is_imem(off)) begin
      if (m_load_en) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) m_mem[word][8*b +: 8] = dat[8*b +: 8];
        if (m_cnt < 1023) m_cnt++;
      end
    end else if (off == 13'h1000 && sel[0]) begin
      if (dat[1] && !m_load_en) m_cnt = 0;
      m_core_reset = dat[0];
      m_load_en    = dat[1];
    end
  endtask

  // One in-region bus transaction; entered and left just after a rising edge.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input int idle, output logic [31:0] rd);
    logic [12:0] off;
    logic [8:0]  word;
    logic        live, got;
    int          lat;
    off  = adr[12:0];
    word = adr[10:2];
    live = is_imem(off) && m_load_en;
    exp_web = !we; exp_addr = word; exp_din = dat; exp_wmask = sel; exp_rd = !we;
    exp_csb_cnt = live ? 1 : 0;
    if (is_imem(off))         exp_dat = live ? m_mem[word] : 32'h0;
    else if (off == 13'h1000) exp_dat = {30'h0, m_load_en, m_core_reset};
    else if (off == 13'h1004) exp_dat = 32'(m_cnt);
    else                      exp_dat = 32'h0;
    csb_cnt = 0;
    pending = 1'b1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_sel_i = sel; wbs_dat_i = dat;
    lat = 0; got = 1'b0;
    while (!got && lat < 16) begin
      @(posedge wb_clk_i);
      lat++;
      @(negedge wb_clk_i);
      got = wbs_ack_o;
    end
    rd = wbs_dat_o;
    check("ack_seen", 32'(got), 32'd1);
    check("ack_latency", 32'(lat), live ? (we ? 32'd2 : 32'd3) : 32'd1);
    if (got && we) model_write(off, sel, dat);
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    check("ack_width", 32'(wbs_ack_o), 32'd0);
    repeat (idle) begin @(posedge wb_clk_i); #1; end
  endtask

  function automatic logic [31:0] imem_adr(input logic [8:0] word);
    return BASE + {21'h0, word, 2'b00};
  endfunction

  logic [31:0] rd, v;
  int          nack;

  initial begin
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    pending = 1'b0; mon_on = 1'b0; csb_cnt = 0; exp_csb_cnt = 0;
    exp_web = 1'b1; exp_rd = 1'b0; exp_addr = '0; exp_din = '0; exp_dat = '0; exp_wmask = '0;
    m_core_reset = 1'b1; m_load_en = 1'b0; m_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      v = $urandom;
      sram_mem[i] = v;
      m_mem[i] = v;
    end
    sram_mem[5] = 32'h1234_5678; m_mem[5] = 32'h1234_5678;
    sram_mem[7] = 32'h1122_3344; m_mem[7] = 32'h1122_3344;

    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_csb0", 32'(sram_csb0), 32'd1);
    check("rst_web0", 32'(sram_web0), 32'd1);
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_wmask0", 32'(sram_wmask0), 32'h0);
    check("rst_addr0", 32'(sram_addr0), 32'h0);
    check("rst_din0", sram_din0, 32'h0);
    mon_on = 1'b1;
    @(posedge wb_clk_i); #1;

    xfer(1'b0, BASE + 32'h1000, 4'hF, 32'h0, 0, rd);
    check("ctrl_after_reset", rd, 32'h1);

    // Window locked: write is acked without touching the SRAM, read returns zero.
    xfer(1'b1, BASE + 32'h0010, 4'hF, 32'hDEAD_BEEF, 1, rd);
    xfer(1'b0, BASE + 32'h0010, 4'hF, 32'h0, 1, rd);
    check("locked_read", rd, 32'h0);

    // Program load.
    xfer(1'b1, BASE + 32'h1000, 4'h1, 32'h3, 0, rd);
    xfer(1'b1, imem_adr(9'd0), 4'hF, 32'h0050_0093, 0, rd);
    xfer(1'b0, BASE + 32'h1004, 4'hF, 32'h0, 0, rd);
    check("status_after_one", rd, 32'h1);
    xfer(1'b0, imem_adr(9'd0), 4'hF, 32'h0, 0, rd);
    check("readback_word0", rd, 32'h0050_0093);
    xfer(1'b0, BASE + 32'h0014, 4'hF, 32'h0, 0, rd);
    check("readback_word5", rd, 32'h1234_5678);

    // Partial write: only byte 1 changes.
    xfer(1'b1, imem_adr(9'd7), 4'h2, 32'hAABB_CCDD, 0, rd);
    xfer(1'b0, imem_adr(9'd7), 4'hF, 32'h0, 0, rd);
    check("partial_word7", rd, 32'h1122_CC44);

    // Other in-region offset: acked, reads zero.
    xfer(1'b0, BASE + 32'h1800, 4'hF, 32'h0, 0, rd);
    check("unmapped_read", rd, 32'h0);

    // Counter saturation, then clear by re-opening the load session.
    xfer(1'b1, BASE + 32'h1000, 4'h1, 32'h1, 0, rd);
    xfer(1'b1, BASE + 32'h1000, 4'h1, 32'h3, 0, rd);
    for (int i = 0; i < 1030; i++)
      xfer(1'b1, imem_adr(9'($urandom_range(0, 511))), 4'($urandom_range(0, 15)), $urandom, 0, rd);
    xfer(1'b0, BASE + 32'h1004, 4'hF, 32'h0, 0, rd);
    check("status_saturated", rd, 32'd1023);
    xfer(1'b1, BASE + 32'h1000, 4'h1, 32'h1, 0, rd);
    xfer(1'b1, BASE + 32'h1000, 4'h1, 32'h3, 0, rd);
    xfer(1'b0, BASE + 32'h1004, 4'hF, 32'h0, 0, rd);
    check("status_cleared", rd, 32'd0);

    // Bus abort during a write: SRAM write and count happen, ack does not.
    exp_web = 1'b0; exp_addr = 9'd9; exp_din = 32'hCAFE_F00D; exp_wmask = 4'hF;
    csb_cnt = 0; pending = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = imem_adr(9'd9); wbs_sel_i = 4'hF; wbs_dat_i = 32'hCAFE_F00D;
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    repeat (4) begin @(posedge wb_clk_i); #1; end
    check("abort_sram_cycles", 32'(csb_cnt), 32'd1);
    model_write(13'h0024, 4'hF, 32'hCAFE_F00D);
    xfer(1'b0, imem_adr(9'd9), 4'hF, 32'h0, 0, rd);
    check("abort_write_landed", rd, 32'hCAFE_F00D);
    xfer(1'b0, BASE + 32'h1004, 4'hF, 32'h0, 0, rd);
    check("abort_counted", rd, 32'd1);

    // Out-of-region request is never acked.
    csb_cnt = 0; pending = 1'b0; nack = 0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = BASE + 32'h2000; wbs_sel_i = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) nack++;
    end
    check("oor_acks", 32'(nack), 32'd0);
    check("oor_sram_cycles", 32'(csb_cnt), 32'd0);
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;

    // Randomized mix.
    for (int t = 0; t < 300; t++) begin
      int k;
      logic [12:0] off;
      logic [3:0]  sel;
      logic [31:0] dat;
      k   = $urandom_range(0, 9);
      sel = 4'($urandom_range(0, 15));
      dat = $urandom;
      if (k <= 5) begin
        off = {2'b00, 9'($urandom_range(0, 511)), 2'b00};
      end else if (k == 6) begin
        off = 13'h1000;
        dat[1] = ($urandom_range(0, 3) != 0);
        sel[0] = ($urandom_range(0, 3) != 0);
      end else if (k == 7) begin
        off = 13'h1004;
      end else begin
        off = 13'(32'h800 + 4 * $urandom_range(0, 1535));
        if (off == 13'h1000 || off == 13'h1004) off = 13'h1008;
      end
      xfer(1'($urandom_range(0, 1)), BASE + {19'h0, off}, sel, dat, $urandom_range(0, 2), rd);
    end

    // Reset while a read is in SRD.
    xfer(1'b1, BASE + 32'h1000, 4'h1, 32'h3, 0, rd);
    exp_web = 1'b1; exp_addr = 9'd3; csb_cnt = 0; pending = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = imem_adr(9'd3); wbs_sel_i = 4'hF;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check("srd_csb_low", 32'(sram_csb0), 32'd0);
    @(posedge wb_clk_i); #1;
    check("rst_srd_csb0", 32'(sram_csb0), 32'd1);
    check("rst_srd_ack", 32'(wbs_ack_o), 32'd0);
    m_core_reset = 1'b1; m_load_en = 1'b0; m_cnt = 0;
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    xfer(1'b0, BASE + 32'h1000, 4'hF, 32'h0, 0, rd);
    check("ctrl_after_midrst", rd, 32'h1);

    // Release the core.
    xfer(1'b1, BASE + 32'h1000, 4'h1, 32'h0, 0, rd);
    @(negedge wb_clk_i);
    check("core_reset_released", 32'(core_reset), 32'd0);

    repeat (2) @(posedge wb_clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
